// File: rtl/sdio_data_pkg.sv
// Shared definitions for the SDIO data transfer scheduler: state encoding,
// zero-length substitutions and the PHY data-count width.
package sdio_data_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } xfer_state_t;

  localparam int DATA_COUNT_W = 13;

  localparam logic [DATA_COUNT_W-1:0] BLOCK_SIZE_ZERO_VAL = 13'd2048;
  localparam logic [DATA_COUNT_W-1:0] BYTE_COUNT_ZERO_VAL = 13'd512;

  // A zero length field encodes the largest length of its mode.
  function automatic logic [DATA_COUNT_W-1:0] phy_data_count(
    input logic        block_mode,
    input logic [11:0] block_size,
    input logic [8:0]  byte_count
  );
    logic [DATA_COUNT_W-1:0] result;
    if (block_mode) begin
      result = (block_size == 12'd0) ? BLOCK_SIZE_ZERO_VAL : {1'b0, block_size};
    end else begin
      result = (byte_count == 9'd0) ? BYTE_COUNT_ZERO_VAL : {4'b0, byte_count};
    end
    return result;
  endfunction

endpackage

// File: rtl/sdio_xfer_watchdog.sv
// Per-block watchdog: clearable up-counter that stops at and flags
// TIMEOUT_CYCLES-1.
module sdio_xfer_watchdog
  import sdio_data_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk_x2,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk_x2) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != TERM_VAL)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign terminal = (count_reg == TERM_VAL);

endmodule

// File: rtl/sdio_data_xfer_sched.sv
// Block-level sequencer for the SDIO data PHY: runs one byte-mode transfer or
// N blocks, one activate/finished handshake per block, with abort and timeout.
module sdio_data_xfer_sched
  import sdio_data_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int GAP_CYCLES     = 4,
  parameter int MAX_BLOCK_SIZE = 2048
) (
  input  logic                    clk_x2,
  input  logic                    rst,
  input  logic                    i_xfer_start,
  input  logic                    i_write_flag,
  input  logic                    i_block_mode,
  input  logic [11:0]             i_block_size,
  input  logic [8:0]              i_byte_count,
  input  logic [8:0]              i_block_count,
  input  logic                    i_abort,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_crc_err,
  output logic                    o_timeout,
  output logic [8:0]              o_blocks_done,
  output logic                    o_phy_activate,
  output logic                    o_phy_write_flag,
  output logic [DATA_COUNT_W-1:0] o_phy_data_count,
  input  logic                    i_phy_finished,
  input  logic                    i_phy_crc_good
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  xfer_state_t state_reg, state_next;

  logic                    block_mode_reg;
  logic                    count_finite_reg;
  logic                    abort_pending_reg;
  logic [11:0]             block_size_reg;
  logic [8:0]              byte_count_reg;
  logic [8:0]              remaining_reg;
  logic [GAP_W-1:0]        gap_cnt_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    crc_err_reg;
  logic                    timeout_reg;
  logic                    activate_reg;
  logic                    write_flag_reg;
  logic [8:0]              blocks_done_reg;
  logic [DATA_COUNT_W-1:0] data_count_reg;

  logic        wd_terminal;
  logic        abort_seen;
  logic        last_block;
  logic        gap_last;
  logic [11:0] size_eff;

  sdio_xfer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_x2   (clk_x2),
    .rst      (rst),
    .clear    (state_reg == ST_LOAD),
    .enable   (state_reg == ST_ACTIVE),
    .terminal (wd_terminal)
  );

  // Abort is remembered once seen so a short pulse mid-block still ends the
  // transfer at the following block boundary.
  assign abort_seen = abort_pending_reg | i_abort;
  assign last_block = !block_mode_reg || (count_finite_reg && (remaining_reg == 9'd0));
  assign gap_last   = (int'(gap_cnt_reg) >= GAP_CYCLES - 1);
  assign size_eff   = (int'(block_size_reg) > MAX_BLOCK_SIZE) ? 12'(MAX_BLOCK_SIZE)
                                                              : block_size_reg;

  always_ff @(posedge clk_x2) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (i_xfer_start) state_next = ST_LOAD;
      ST_LOAD:    state_next = ST_ACTIVE;
      // Finished wins over a watchdog terminal count on the same cycle.
      ST_ACTIVE:  if (i_phy_finished || wd_terminal) state_next = ST_RELEASE;
      ST_RELEASE: begin
        if (!i_phy_finished) begin
          if (timeout_reg || abort_seen || last_block) state_next = ST_DONE;
          else                                         state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (abort_seen)    state_next = ST_DONE;
        else if (gap_last) state_next = ST_LOAD;
      end
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_x2) begin
    if (rst) begin
      block_mode_reg    <= 1'b0;
      count_finite_reg  <= 1'b0;
      abort_pending_reg <= 1'b0;
      block_size_reg    <= '0;
      byte_count_reg    <= '0;
      remaining_reg     <= '0;
      gap_cnt_reg       <= '0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      crc_err_reg       <= 1'b0;
      timeout_reg       <= 1'b0;
      activate_reg      <= 1'b0;
      write_flag_reg    <= 1'b0;
      blocks_done_reg   <= '0;
      data_count_reg    <= '0;
    end else begin
      busy_reg     <= (state_next != ST_IDLE);
      done_reg     <= (state_next == ST_DONE);
      activate_reg <= (state_next == ST_ACTIVE);

      if ((state_reg != ST_IDLE) && i_abort) abort_pending_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (i_xfer_start) begin
            block_mode_reg    <= i_block_mode;
            block_size_reg    <= i_block_size;
            byte_count_reg    <= i_byte_count;
            remaining_reg     <= i_block_count;
            count_finite_reg  <= (i_block_count != 9'd0);
            write_flag_reg    <= i_write_flag;
            abort_pending_reg <= 1'b0;
            crc_err_reg       <= 1'b0;
            timeout_reg       <= 1'b0;
            blocks_done_reg   <= '0;
          end
        end
        ST_LOAD: data_count_reg <= phy_data_count(block_mode_reg, size_eff, byte_count_reg);
        ST_ACTIVE: begin
          if (i_phy_finished) begin
            crc_err_reg     <= crc_err_reg | ~i_phy_crc_good;
            blocks_done_reg <= blocks_done_reg + 9'd1;
            remaining_reg   <= remaining_reg - 9'd1;
          end else if (wd_terminal) begin
            timeout_reg <= 1'b1;
          end
        end
        ST_RELEASE: gap_cnt_reg <= '0;
        ST_GAP:     gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
        default: ;
      endcase
    end
  end

  assign o_busy           = busy_reg;
  assign o_done           = done_reg;
  assign o_crc_err        = crc_err_reg;
  assign o_timeout        = timeout_reg;
  assign o_blocks_done    = blocks_done_reg;
  assign o_phy_activate   = activate_reg;
  assign o_phy_write_flag = write_flag_reg;
  assign o_phy_data_count = data_count_reg;

endmodule

// File: tb/tb_sdio_data_xfer_sched.sv
// Self-checking bench for sdio_data_xfer_sched: reactive PHY model, an interval
// schedule model of each transfer checked every cycle, and literal checks.
module tb_sdio_data_xfer_sched;

  localparam int TO  = 100;
  localparam int GAP = 4;

  logic        clk_x2 = 1'b0;
  logic        rst = 1'b1;
  logic        i_xfer_start = 1'b0;
  logic        i_write_flag = 1'b0;
  logic        i_block_mode = 1'b0;
  logic [11:0] i_block_size = '0;
  logic [8:0]  i_byte_count = '0;
  logic [8:0]  i_block_count = '0;
  logic        i_abort = 1'b0;
  logic        i_phy_finished = 1'b0;
  logic        i_phy_crc_good = 1'b0;
  logic        o_busy, o_done, o_crc_err, o_timeout;
  logic [8:0]  o_blocks_done;
  logic        o_phy_activate, o_phy_write_flag;
  logic [12:0] o_phy_data_count;

  sdio_data_xfer_sched #(
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES    (GAP),
    .MAX_BLOCK_SIZE(2048)
  ) dut (
    .clk_x2          (clk_x2),
    .rst             (rst),
    .i_xfer_start    (i_xfer_start),
    .i_write_flag    (i_write_flag),
    .i_block_mode    (i_block_mode),
    .i_block_size    (i_block_size),
    .i_byte_count    (i_byte_count),
    .i_block_count   (i_block_count),
    .i_abort         (i_abort),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_crc_err       (o_crc_err),
    .o_timeout       (o_timeout),
    .o_blocks_done   (o_blocks_done),
    .o_phy_activate  (o_phy_activate),
    .o_phy_write_flag(o_phy_write_flag),
    .o_phy_data_count(o_phy_data_count),
    .i_phy_finished  (i_phy_finished),
    .i_phy_crc_good  (i_phy_crc_good)
  );

  always #5 clk_x2 = ~clk_x2;

  int cyc = 0;
  always @(posedge clk_x2) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-block PHY behaviour: latency in activate cycles (0 = never) and CRC result.
  int lat_tab[0:1023];
  bit crc_tab[0:1023];

  int phy_blk = 0;
  int phy_cnt = 0;
  bit phy_prev = 1'b0;

  always @(negedge clk_x2) begin
    if (!o_busy) phy_blk = 0;
    if (o_phy_activate) begin
      if (!phy_prev) begin
        phy_blk++;
        phy_cnt = 0;
      end
      phy_cnt++;
      if (lat_tab[phy_blk] != 0 && phy_cnt == lat_tab[phy_blk]) begin
        i_phy_finished = 1'b1;
        i_phy_crc_good = crc_tab[phy_blk];
      end else begin
        i_phy_finished = 1'b0;
        i_phy_crc_good = 1'b0;
      end
    end else begin
      phy_cnt = 0;
      i_phy_finished = 1'b0;
      i_phy_crc_good = 1'b0;
    end
    phy_prev = o_phy_activate;
  end

  // Transfer model: activate window of each block, timeout flags and done cycle.
  bit mdl_on = 1'b0;
  int mdl_s, mdl_done, mdl_n, mdl_dc;
  bit mdl_wr;
  int mdl_a[1:1024];
  int mdl_len[1:1024];
  bit mdl_to[1:1024];

  int st_acts, st_first, st_min_low, st_low, st_done, st_len, st_dc;
  bit st_prev;

  always @(negedge clk_x2) begin : compare
    int rel, e_act, e_bd, e_crc, e_to, fin_end;
    if (mdl_on && cyc > mdl_s) begin
      rel = cyc - mdl_s;
      if (rel == 1) begin
        st_acts = 0; st_first = -1; st_min_low = 1 << 30; st_low = 0;
        st_done = 0; st_len = 0; st_dc = 0; st_prev = 1'b0;
      end
      e_act = 0; e_bd = 0; e_crc = 0; e_to = 0;
      for (int k = 1; k <= mdl_n; k++) begin
        fin_end = mdl_a[k] + mdl_len[k] - 1;
        if (cyc >= mdl_a[k] && cyc <= fin_end) e_act = 1;
        if (cyc > fin_end) begin
          if (mdl_to[k]) e_to = 1;
          else begin
            e_bd++;
            if (!crc_tab[k]) e_crc = 1;
          end
        end
      end
      chk("activate", o_phy_activate, e_act);
      chk("busy", o_busy, int'(cyc <= mdl_done));
      chk("done", o_done, int'(cyc == mdl_done));
      chk("blocks_done", o_blocks_done, e_bd % 512);
      chk("crc_err", o_crc_err, e_crc);
      chk("timeout", o_timeout, e_to);
      chk("write_flag", o_phy_write_flag, mdl_wr);
      if (e_act != 0) chk("data_count", o_phy_data_count, mdl_dc);

      if (o_phy_activate) begin
        if (!st_prev) begin
          st_acts++;
          if (st_acts == 1) st_first = rel;
          else if (st_low < st_min_low) st_min_low = st_low;
          st_len = 0;
        end
        st_len++;
        st_dc = o_phy_data_count;
      end else if (st_prev) st_low = 1;
      else st_low++;
      st_prev = o_phy_activate;
      if (o_done) st_done++;
    end
  end

  task automatic set_phy(input int lat, input bit good);
    for (int k = 0; k < 1024; k++) begin
      lat_tab[k] = lat;
      crc_tab[k] = good;
    end
  endtask

  task automatic run_xfer(input bit wr, input bit bm, input int size, input int bytec,
                          input int bcnt, input int nblk, input int abort_blk,
                          input int stray_blk);
    int s, a, len, k;
    bit stray_done;
    @(negedge clk_x2);
    i_write_flag  = wr;
    i_block_mode  = bm;
    i_block_size  = size[11:0];
    i_byte_count  = bytec[8:0];
    i_block_count = bcnt[8:0];
    i_xfer_start  = 1'b1;
    s = cyc;
    a = s + 2;
    len = 0;
    for (k = 1; k <= 1024; k++) begin
      len = (lat_tab[k] == 0 || lat_tab[k] > TO) ? TO : lat_tab[k];
      mdl_a[k]   = a;
      mdl_len[k] = len;
      mdl_to[k]  = (lat_tab[k] == 0 || lat_tab[k] > TO);
      if (mdl_to[k] || k == nblk) break;
      a = a + len + GAP + 2;
    end
    mdl_n    = k;
    mdl_done = a + len + 1;
    mdl_wr   = wr;
    mdl_dc   = bm ? ((size == 0) ? 2048 : size) : ((bytec == 0) ? 512 : bytec);
    mdl_s    = s;
    mdl_on   = 1'b1;
    @(negedge clk_x2);
    i_xfer_start = 1'b0;
    stray_done = 1'b0;
    while (cyc <= mdl_done + 2) begin
      @(posedge clk_x2);
      #1;
      if (i_xfer_start) i_xfer_start = 1'b0;
      if (abort_blk != 0 && phy_blk == abort_blk) i_abort = 1'b1;
      if (stray_blk != 0 && !stray_done && phy_blk == stray_blk) begin
        i_xfer_start = 1'b1;
        i_write_flag = !wr;
        i_block_mode = 1'b0;
        i_byte_count = 9'd7;
        stray_done   = 1'b1;
      end
    end
    i_abort = 1'b0;
    i_xfer_start = 1'b0;
    @(negedge clk_x2);
    mdl_on = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_crc_err"}, o_crc_err, 0);
    chk({tag, "_timeout"}, o_timeout, 0);
    chk({tag, "_blocks_done"}, o_blocks_done, 0);
    chk({tag, "_activate"}, o_phy_activate, 0);
    chk({tag, "_write_flag"}, o_phy_write_flag, 0);
    chk({tag, "_data_count"}, o_phy_data_count, 0);
  endtask

  initial begin
    set_phy(4, 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk_x2);
    chk_all_zero("reset");
    rst = 1'b0;

    // Byte-mode read, byte count 0 -> 512 bytes
    run_xfer(1'b0, 1'b0, 0, 0, 0, 1, 0, 0);
    chk("byte_first_act", st_first, 2);
    chk("byte_dc", st_dc, 512);
    chk("byte_done_cnt", st_done, 1);
    chk("byte_blocks", o_blocks_done, 1);
    chk("byte_crc", o_crc_err, 0);

    // Block write 3 x 64, with an ignored start pulse during block 2
    set_phy(3, 1'b1);
    run_xfer(1'b1, 1'b1, 64, 0, 3, 3, 0, 2);
    chk("blk_acts", st_acts, 3);
    chk("blk_dc", st_dc, 64);
    chk("blk_min_gap", st_min_low, 6);
    chk("blk_blocks", o_blocks_done, 3);
    chk("blk_done_cnt", st_done, 1);
    chk("blk_wflag", o_phy_write_flag, 1);

    // Same, block 2 returns a bad CRC
    crc_tab[2] = 1'b0;
    run_xfer(1'b1, 1'b1, 64, 0, 3, 3, 0, 0);
    chk("crc_acts", st_acts, 3);
    chk("crc_blocks", o_blocks_done, 3);
    chk("crc_flag", o_crc_err, 1);
    repeat (5) @(negedge clk_x2);
    chk("crc_sticky", o_crc_err, 1);

    // Infinite mode, size 0, abort mid-block 5
    set_phy(3, 1'b1);
    run_xfer(1'b0, 1'b1, 0, 0, 0, 5, 5, 0);
    chk("inf_acts", st_acts, 5);
    chk("inf_dc", st_dc, 2048);
    chk("inf_blocks", o_blocks_done, 5);
    chk("inf_done_cnt", st_done, 1);

    // Block 1 finishes exactly at the terminal count, block 2 never finishes
    lat_tab[1] = TO;
    lat_tab[2] = 0;
    run_xfer(1'b0, 1'b1, 16, 0, 3, 3, 0, 0);
    chk("to_acts", st_acts, 2);
    chk("to_act_len", st_len, 100);
    chk("to_flag", o_timeout, 1);
    chk("to_blocks", o_blocks_done, 1);
    chk("to_done_cnt", st_done, 1);

    // Reset during block 2
    set_phy(5, 1'b1);
    @(negedge clk_x2);
    i_write_flag = 1'b1; i_block_mode = 1'b1; i_block_size = 12'd64;
    i_block_count = 9'd3; i_xfer_start = 1'b1;
    @(negedge clk_x2);
    i_xfer_start = 1'b0;
    for (int n = 0; n < 200 && phy_blk != 2; n++) @(negedge clk_x2);
    chk("rst_reach_blk2", phy_blk, 2);
    chk("rst_act_before", o_phy_activate, 1);
    rst = 1'b1;
    @(negedge clk_x2);
    chk_all_zero("midrst");
    rst = 1'b0;

    // Fresh byte-mode write after the reset
    set_phy(1, 1'b1);
    run_xfer(1'b1, 1'b0, 0, 5, 0, 1, 0, 0);
    chk("post_first_act", st_first, 2);
    chk("post_dc", st_dc, 5);
    chk("post_blocks", o_blocks_done, 1);

    // Infinite run past 511 blocks; abort coincides with finish of block 513
    set_phy(2, 1'b1);
    run_xfer(1'b0, 1'b1, 8, 0, 0, 513, 513, 0);
    chk("wrap_acts", st_acts, 513);
    chk("wrap_blocks", o_blocks_done, 1);
    chk("wrap_done_cnt", st_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
